int_arbiter: RTL
================

# int_arbiter

Memory-mapped interrupt receiver that sits between peripheral interrupt lines (the timer's `int_sig_o` and siblings) and the core's interrupt entry. It latches level requests into pending bits and arbitrates by fixed priority. It presents one request with its source id to the core, takes the core's acknowledge as a claim, and holds that source in service until software writes a completion. Register access uses the same peripheral bus as the other perips: `addr_i`/`data_i`/`we_i` in, combinational `data_o` out.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..31; id = source index.
- `clk`  input  1  clock, all state on rising edge.
- `rst`  input  1  reset: synchronous, active-high (`RstEnable`).
- `data_i`  input  32  bus write data.
- `addr_i`  input  32  bus address; only `addr_i[3:0]` decoded.
- `we_i`  input  1  bus write strobe (`WriteEnable`).
- `data_o`  output  32  combinational read data.
- `src_i`  input  NUM_SRC  level interrupt lines, active-high (`INT_ASSERT`).
- `irq_o`  output  1  registered interrupt request to core.
- `irq_id_o`  output  5  id of the requested source; valid while `irq_o`=1, else 0.
- `irq_ack_i`  input  1  one-cycle core acknowledge (trap taken).

## Operation
- Registers:
  - 0x0 CTRL: `[0]` global enable, other bits read 0.
  - 0x4 ENABLE: `[NUM_SRC-1:0]` per-source enable.
  - 0x8 PENDING: read-only; writes are ignored.
  - 0xC CLAIM: read gives `{in_svc_valid, 26'b0, in_svc_id[4:0]}`. A write is a completion.
- Other offsets read 0; writes to them are ignored.
- Pending set: `pending[i]` <= 1 when `src_i[i]`=1 and source i is not in service. It stays set until claimed, independent of later `src_i` level. ENABLE does not gate pending capture.
- Eligible sources: `pending & ENABLE`, and only when `CTRL[0]`=1. The lowest index wins.
- State machine:
  - IDLE: `irq_o`=0. If any source is eligible, latch the winner id, go to REQ.
  - REQ: `irq_o`=1, `irq_id_o`=latched id. The id stays fixed in REQ; there is no preemption by a higher-priority arrival.
    - On `irq_ack_i`: clear `pending[id]`, set in-service {valid, id}, go to SVC.
    - If the latched source stops being eligible (enable cleared or global disable) without ack: go to IDLE.
  - SVC: `irq_o`=0. A write to 0xC with `data_i[4:0]`==in-service id clears in-service and goes to IDLE. A mismatching id is ignored.
- `irq_ack_i` outside REQ is ignored. Completion writes outside SVC are ignored.
- Ack and the disable condition in the same cycle: ack wins.
- Simultaneous `src_i` set and claim of the same source: claim wins, because the source enters service and its capture is masked.
- Level re-trigger: if the source is still high after completion, pending sets again on the next edge.

## Timing
- Reset values: `irq_o`=0, `irq_id_o`=0, CTRL, ENABLE, PENDING and in-service all 0, state IDLE. `data_o`=0 while `rst`=1.
- Request latency:
  - `src_i` rises before edge n, so pending=1 after edge n.
  - With the source eligible, `irq_o`=1 after edge n+1.
- Ack: `irq_ack_i` sampled at edge m gives `irq_o`=0 and CLAIM valid after edge m.
- Complete: write at edge k gives IDLE after edge k. The next request comes no earlier than edge k+1.
- Register writes take effect at the write edge and are seen by the arbitration on the next cycle.
- Reset mid-REQ or mid-SVC returns to IDLE and drops all pending bits.

## Structure
- Shared defines file holds:
  - register offsets `INTA_CTRL`/`INTA_EN`/`INTA_PEND`/`INTA_CLAIM`;
  - state encodings IDLE/REQ/SVC;
  - the existing `INT_ASSERT`/`INT_DEASSERT`, `ZeroWord`, `RstEnable` and `WriteEnable`.
- One sub-module, `prio_enc`: parameterised NUM_SRC lowest-index-first encoder with outputs {any, id[4:0]}.

## Test plan
- Basic request, NUM_SRC=8: CTRL=1, ENABLE=0xFF, pulse `src_i[3]` one cycle.
  - Required: PENDING=0x08, then `irq_o`=1 with `irq_id_o`=3 two edges after the rise.
  - Ack: CLAIM reads 0x80000003 and PENDING=0.
  - Write 3 to 0xC: CLAIM reads 0.
- Priority: `src_i`=0x24 together.
  - Required: id 2 is served first.
  - After completing 2: id 5 is requested, with no gap beyond one cycle.
- Masking: ENABLE=0x00 with `src_i[1]` high.
  - Required: PENDING=0x02 and `irq_o` stays 0.
  - Set ENABLE=0x02: `irq_o`=1 with id 1.
  - In REQ, clear CTRL[0]: `irq_o` drops and PENDING is still 0x02.
- Level hold: hold `src_i[0]` high through ack and completion.
  - Required: pending stays 0 during SVC and re-sets one edge after completion. Then a second request.
- Bad complete and stray ack: in SVC, write id 4 while id 0 is in service, and pulse `irq_ack_i` in IDLE.
  - Required: the wrong-id write leaves the state unchanged, and the IDLE ack causes no state change.
- Reset mid-SVC: assert `rst` for one cycle.
  - Required: all registers read 0 and `irq_o`=0.

Source files
------------

// File: rtl/int_arbiter_pkg.sv
// int_arbiter_pkg
//   Shared defines for the interrupt arbiter: register offsets, FSM state
//   encodings and the common perip-bus constants.
package int_arbiter_pkg;

    // Register offsets (only addr_i[3:0] is decoded)
    localparam logic [3:0] INTA_CTRL  = 4'h0;
    localparam logic [3:0] INTA_EN    = 4'h4;
    localparam logic [3:0] INTA_PEND  = 4'h8;
    localparam logic [3:0] INTA_CLAIM = 4'hC;

    // Arbiter FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SVC  = 2'd2;

    // Common perip constants
    localparam logic        INT_ASSERT   = 1'b1;
    localparam logic        INT_DEASSERT = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteEnable  = 1'b1;

endpackage

// File: rtl/int_arbiter_if.sv
// int_arbiter_if
//   Bundles the perip register bus, the interrupt lines and the core-side
//   request/acknowledge of the interrupt arbiter.
//   Bus     : data_i, addr_i, we_i (in) / data_o (out, combinational)
//   Sources : src_i[NUM_SRC-1:0] level interrupt lines
//   Core    : irq_o, irq_id_o (out) / irq_ack_i (in)
//   Debug   : dbg_state, current arbiter FSM state
//
//   Request handshake: irq_o acts as valid and irq_ack_i as ready. While
//   irq_o=1 the id on irq_id_o is held stable; the claim happens on the
//   rising edge where irq_o=1 and irq_ack_i=1. irq_ack_i without irq_o is
//   ignored.
interface int_arbiter_if #(
    parameter int NUM_SRC = 8
);
    logic [31:0]        data_i;
    logic [31:0]        addr_i;
    logic               we_i;
    logic [31:0]        data_o;
    logic [NUM_SRC-1:0] src_i;
    logic               irq_o;
    logic [4:0]         irq_id_o;
    logic               irq_ack_i;
    logic [1:0]         dbg_state;

    modport slave (
        input  data_i, addr_i, we_i, src_i, irq_ack_i,
        output data_o, irq_o, irq_id_o, dbg_state
    );

    modport master (
        output data_i, addr_i, we_i, src_i, irq_ack_i,
        input  data_o, irq_o, irq_id_o, dbg_state
    );
endinterface

// File: rtl/int_arbiter_prio_enc.sv
// prio_enc
//   Fixed-priority encoder, lowest index wins.
//   req : request vector
//   any : at least one request bit set
//   id  : index of the lowest set bit (0 when any=0)
module prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [4:0]         id
);
    always_comb begin
        any = |req;
        id  = 5'd0;
        // Scan downward so the lowest set index is the last one assigned
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) id = 5'(i);
        end
    end
endmodule

// File: rtl/int_arbiter.sv
// int_arbiter
//   Memory-mapped interrupt receiver. Level requests are latched into
//   pending bits, arbitrated lowest-index-first, presented to the core and
//   held in service until software writes a completion to CLAIM.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : int_arbiter_if.slave (register bus, src_i, irq/ack, dbg_state)
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input logic          clk,
    input logic          rst,
    int_arbiter_if.slave bus
);
    logic [1:0]         state;
    logic [4:0]         latched_id;
    logic               ctrl_en;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic               svc_valid;
    logic [4:0]         svc_id;

    logic [NUM_SRC-1:0] eligible;
    logic [31:0]        elig_ext;
    logic               latched_ok;
    logic               win_any;
    logic [4:0]         win_id;
    logic               ack_take;
    logic               complete;
    logic               wr_ctrl;
    logic               wr_en;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] capture_mask;
    logic               unused_ok;

    always_comb begin
        eligible   = ctrl_en ? (pending & enable) : '0;
        elig_ext   = 32'(eligible);
        latched_ok = elig_ext[latched_id];
        ack_take   = (state == REQ) && bus.irq_ack_i;
        wr_ctrl    = (bus.we_i == WriteEnable) && (bus.addr_i[3:0] == INTA_CTRL);
        wr_en      = (bus.we_i == WriteEnable) && (bus.addr_i[3:0] == INTA_EN);
        complete   = (state == SVC) && (bus.we_i == WriteEnable) &&
                     (bus.addr_i[3:0] == INTA_CLAIM) && (bus.data_i[4:0] == svc_id);
        claim_mask = ack_take ? (NUM_SRC'(1) << latched_id) : '0;
        // Capture is blocked for the source already in service and for the
        // one being claimed this edge, so a claim beats a same-cycle set.
        capture_mask = claim_mask | (svc_valid ? (NUM_SRC'(1) << svc_id) : '0);
    end

    prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .req (eligible),
        .any (win_any),
        .id  (win_id)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= IDLE;
            latched_id <= 5'd0;
            ctrl_en    <= 1'b0;
            enable     <= '0;
            pending    <= '0;
            svc_valid  <= 1'b0;
            svc_id     <= 5'd0;
        end else begin
            if (wr_ctrl) ctrl_en <= bus.data_i[0];
            if (wr_en)   enable  <= bus.data_i[NUM_SRC-1:0];
            pending <= (pending | (bus.src_i & ~capture_mask)) & ~claim_mask;

            case (state)
                IDLE: begin
                    if (win_any) begin
                        latched_id <= win_id;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // Ack has priority over the loss of eligibility
                    if (ack_take) begin
                        svc_valid <= 1'b1;
                        svc_id    <= latched_id;
                        state     <= SVC;
                    end else if (!latched_ok) begin
                        state <= IDLE;
                    end
                end
                SVC: begin
                    if (complete) begin
                        svc_valid <= 1'b0;
                        svc_id    <= 5'd0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.irq_o     = (state == REQ);
    assign bus.irq_id_o  = (state == REQ) ? latched_id : 5'd0;
    assign bus.dbg_state = state;

    always_comb begin
        bus.data_o = ZeroWord;
        if (rst != RstEnable) begin
            case (bus.addr_i[3:0])
                INTA_CTRL:  bus.data_o = {31'd0, ctrl_en};
                INTA_EN:    bus.data_o = 32'(enable);
                INTA_PEND:  bus.data_o = 32'(pending);
                INTA_CLAIM: bus.data_o = {svc_valid, 26'd0, svc_id};
                default:    bus.data_o = ZeroWord;
            endcase
        end
    end

    assign unused_ok = ^{bus.addr_i[31:4], bus.data_i};

endmodule
